// File: rtl/instruction_fetch_stage.sv
// Fetch front end: owns the PC, drives the combinational instruction memory
// and captures the returned instruction with its PC into the IF/ID register.
// Edge priority: reset > redirect > flush/stall > normal capture.
// Optional fetch-bound check enabled by defining FETCH_BOUND_EN: a normal
// capture attempted at pc >= MEM_DEPTH raises a sticky fault that freezes
// fetch until reset. Without the macro, fault stays 0 and pc wraps freely.
module instruction_fetch_stage #(
    parameter int                PC_W      = 8,
    parameter int                INSTR_W   = 8,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter int                MEM_DEPTH = 36
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic [15:0]        fetch_count,
    output logic               fault
);

`ifdef FETCH_BOUND_EN
    localparam logic BOUND_EN = 1'b1;
`else
    localparam logic BOUND_EN = 1'b0;
`endif

    // One extra bit so a depth equal to 2^PC_W still compares correctly.
    localparam logic [PC_W:0] MEM_DEPTH_W = (PC_W + 1)'(MEM_DEPTH);

    logic [PC_W-1:0]    pc_q,         pc_next;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_next;
    logic [PC_W-1:0]    ifid_pc_q,    ifid_pc_next;
    logic               ifid_valid_q, ifid_valid_next;
    logic [15:0]        count_q,      count_next;
    logic               fault_q,      fault_next;
    logic               bound_hit;

    assign bound_hit = BOUND_EN && ({1'b0, pc_q} >= MEM_DEPTH_W);

    // Next-state selection following the per-edge priority; holds by default.
    always_comb begin
        pc_next         = pc_q;
        ifid_instr_next = ifid_instr_q;
        ifid_pc_next    = ifid_pc_q;
        ifid_valid_next = ifid_valid_q;
        count_next      = count_q;
        fault_next      = fault_q;

        if (fault_q) begin
            // Frozen after a bound fault: everything else is ignored.
            ifid_instr_next = '0;
            ifid_valid_next = 1'b0;
        end else if (redirect) begin
            pc_next         = redirect_pc;
            ifid_instr_next = '0;
            ifid_valid_next = 1'b0;
        end else if (flush) begin
            ifid_instr_next = '0;
            ifid_valid_next = 1'b0;
            if (!stall) begin
                pc_next = pc_q + PC_W'(1);
            end
        end else if (stall) begin
            // Hold pc, IF/ID and the counter.
        end else if (bound_hit) begin
            fault_next      = 1'b1;
            ifid_instr_next = '0;
            ifid_valid_next = 1'b0;
        end else begin
            ifid_instr_next = instr_in;
            ifid_pc_next    = pc_q;
            ifid_valid_next = 1'b1;
            pc_next         = pc_q + PC_W'(1);
            if (count_q != 16'hFFFF) begin
                count_next = count_q + 16'd1;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            count_q      <= '0;
            fault_q      <= 1'b0;
        end else begin
            pc_q         <= pc_next;
            ifid_instr_q <= ifid_instr_next;
            ifid_pc_q    <= ifid_pc_next;
            ifid_valid_q <= ifid_valid_next;
            count_q      <= count_next;
            fault_q      <= fault_next;
        end
    end

    assign pc          = pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_valid  = ifid_valid_q;
    assign fetch_count = count_q;
    assign fault       = fault_q;

endmodule
